// File: rtl/delay_commutator.sv
// Radix-2 MDC delay commutator: lower-input delay, counter-driven switch/bypass
// exchange and upper-output delay, all advancing only on valid input samples.
module delay_commutator #(
  parameter int unsigned D = 8,
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] UI_real,
  input  logic [W-1:0] UI_imag,
  input  logic [W-1:0] LI_real,
  input  logic [W-1:0] LI_imag,
  output logic         out_valid,
  output logic [W-1:0] UO_real,
  output logic [W-1:0] UO_imag,
  output logic [W-1:0] LO_real,
  output logic [W-1:0] LO_imag
);

  localparam int unsigned CW = $clog2(D) + 1;
  localparam int unsigned XW = 2 * W;

  logic [XW-1:0] l_dly [D];
  logic [XW-1:0] u_dly [D];
  logic [CW-1:0] cnt;
  logic [CW-1:0] fill;

  logic [XW-1:0] ui_c;
  logic [XW-1:0] ld_c;
  logic [XW-1:0] a_c;
  logic [XW-1:0] b_c;
  logic          swap_c;

  // Switch decision uses the phase count before this sample's increment.
  always_comb begin
    ui_c   = {UI_real, UI_imag};
    ld_c   = l_dly[D-1];
    swap_c = (cnt >= CW'(D));
    a_c    = swap_c ? ld_c : ui_c;
    b_c    = swap_c ? ui_c : ld_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < D; i++) begin
        l_dly[i] <= '0;
        u_dly[i] <= '0;
      end
      cnt       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      UO_real   <= '0;
      UO_imag   <= '0;
      LO_real   <= '0;
      LO_imag   <= '0;
    end else if (in_valid) begin
      for (int unsigned i = 1; i < D; i++) begin
        l_dly[i] <= l_dly[i-1];
        u_dly[i] <= u_dly[i-1];
      end
      l_dly[0]  <= {LI_real, LI_imag};
      u_dly[0]  <= a_c;
      // Counter is exactly wide enough for 2D states, so it wraps naturally.
      cnt       <= cnt + CW'(1);
      fill      <= (fill == CW'(D)) ? fill : fill + CW'(1);
      out_valid <= (fill == CW'(D));
      {UO_real, UO_imag} <= u_dly[D-1];
      {LO_real, LO_imag} <= b_c;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_commutator.sv
// Scoreboard bench for delay_commutator: D=4 and D=1 instances share stimulus,
// expected outputs come from the block-reordering formula over input history.
module tb_delay_commutator;

  localparam int unsigned W  = 12;
  localparam int unsigned DA = 4;
  localparam int unsigned DB = 1;
  localparam int unsigned XW = 4 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] ui_re, ui_im, li_re, li_im;

  logic         ov_a, ov_b;
  logic [W-1:0] uo_re_a, uo_im_a, lo_re_a, lo_im_a;
  logic [W-1:0] uo_re_b, uo_im_b, lo_re_b, lo_im_b;

  int checks = 0;
  int errors = 0;

  logic [XW-1:0] hist [512];
  logic [XW-1:0] q_a[$];
  logic [XW-1:0] q_b[$];
  logic [XW-1:0] hold_a, hold_b;
  logic          ev_a, ev_b;
  int            k;

  always #5 clk = ~clk;

  delay_commutator #(.D(DA), .W(W)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .UI_real(ui_re), .UI_imag(ui_im), .LI_real(li_re), .LI_imag(li_im),
    .out_valid(ov_a),
    .UO_real(uo_re_a), .UO_imag(uo_im_a), .LO_real(lo_re_a), .LO_imag(lo_im_a)
  );

  delay_commutator #(.D(DB), .W(W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .UI_real(ui_re), .UI_imag(ui_im), .LI_real(li_re), .LI_imag(li_im),
    .out_valid(ov_b),
    .UO_real(uo_re_b), .UO_imag(uo_im_b), .LO_real(lo_re_b), .LO_imag(lo_im_b)
  );

  // hist word layout: {UI_re, UI_im, LI_re, LI_im}; result: {UO_re, UO_im, LO_re, LO_im}
  function automatic logic [XW-1:0] model(input int d, input int idx);
    int b, p, i0, i1;
    logic [XW-1:0] h0, h1;
    b = idx / (2 * d);
    p = idx % (2 * d);
    if (p >= d) begin
      i0 = 2 * d * b + (p - d);
      i1 = i0 + d;
      h0 = hist[i0];
      h1 = hist[i1];
      return {h0[4*W-1:2*W], h1[4*W-1:2*W]};
    end
    i0 = 2 * d * (b - 1) + p;
    i1 = i0 + d;
    h0 = hist[i0];
    h1 = hist[i1];
    return {h0[2*W-1:0], h1[2*W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic check_outs();
    logic [XW-1:0] e;
    chk("valid_d4", XW'(ov_a), XW'(ev_a));
    if (ev_a) begin
      if (q_a.size() == 0) begin
        chk("queue_d4_empty", XW'(1), XW'(0));
        e = hold_a;
      end else e = q_a.pop_front();
      hold_a = e;
    end
    chk(ev_a ? "data_d4" : "hold_d4", {uo_re_a, uo_im_a, lo_re_a, lo_im_a}, hold_a);
    chk("valid_d1", XW'(ov_b), XW'(ev_b));
    if (ev_b) begin
      if (q_b.size() == 0) begin
        chk("queue_d1_empty", XW'(1), XW'(0));
        e = hold_b;
      end else e = q_b.pop_front();
      hold_b = e;
    end
    chk(ev_b ? "data_d1" : "hold_d1", {uo_re_b, uo_im_b, lo_re_b, lo_im_b}, hold_b);
  endtask

  // One clock: check what the previous edge produced, then drive the next cycle.
  task automatic step(input bit r, input bit v, input logic [W-1:0] ur, input logic [W-1:0] ui,
                      input logic [W-1:0] lr, input logic [W-1:0] li);
    @(posedge clk);
    #1;
    check_outs();
    rst      = r;
    in_valid = v;
    ui_re = ur; ui_im = ui; li_re = lr; li_im = li;
    if (r) begin
      ev_a = 1'b0; ev_b = 1'b0;
      hold_a = '0; hold_b = '0;
      q_a.delete(); q_b.delete();
      k = 0;
    end else if (v) begin
      hist[k] = {ur, ui, lr, li};
      ev_a = (k >= int'(DA));
      ev_b = (k >= int'(DB));
      if (ev_a) q_a.push_back(model(DA, k));
      if (ev_b) q_b.push_back(model(DB, k));
      k++;
    end else begin
      ev_a = 1'b0; ev_b = 1'b0;
    end
  endtask

  task automatic sample(input int ur, input int lr);
    step(1'b0, 1'b1, W'(ur), W'(-ur), W'(lr), W'(-lr));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    ui_re = '0; ui_im = '0; li_re = '0; li_im = '0;
    ev_a = 1'b0; ev_b = 1'b0; hold_a = '0; hold_b = '0; k = 0;

    // Reset values, and in_valid held high during reset is ignored
    do_reset();
    step(1'b1, 1'b1, W'(9), W'(9), W'(9), W'(9));
    step(1'b1, 1'b1, W'(9), W'(9), W'(9), W'(9));
    step(1'b1, 1'b0, '0, '0, '0, '0);

    // Continuous stream: UI=k, LI=100+k
    for (int i = 0; i < 16; i++) sample(i, 100 + i);
    step(1'b0, 1'b0, '0, '0, '0, '0);

    // Stream UI=k, LI=50+k
    do_reset();
    for (int i = 0; i < 12; i++) sample(i, 50 + i);
    step(1'b0, 1'b0, '0, '0, '0, '0);

    // Same stream as the first, with random bubbles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++)
          step(1'b0, 1'b0, W'(777), W'(777), W'(777), W'(777));
      end
      sample(i, 100 + i);
    end
    step(1'b0, 1'b0, '0, '0, '0, '0);

    // Mid-stream reset then restart with fresh data
    do_reset();
    for (int i = 0; i < 7; i++) sample(i, 100 + i);
    step(1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 12; i++) sample(200 + i, 300 + i);
    step(1'b0, 1'b0, '0, '0, '0, '0);

    // Extreme values, alternating sign extremes
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 12'h7FF, 12'h800, 12'h800, 12'h7FF);
      else            step(1'b0, 1'b1, 12'h800, 12'h7FF, 12'h7FF, 12'h800);
    end
    step(1'b0, 1'b0, '0, '0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/delay_commutator.md
# delay_commutator

Registered delay-commutator for the radix-2 MDC IFFT pipeline. It takes the paired upper/lower complex sample stream from one butterfly stage and reorders it for the next stage. It applies a D-deep delay on the lower input, a switch/bypass exchange driven by an internal sample counter, and a D-deep delay on the upper output. The switch element is the same one the stage-2 commutator uses, but here the block generates its own control and owns the buffering, so upstream logic drives only data and a valid strobe.

## Interface
- D, 8: delay depth in samples; power of two, 1..16. The switch period is 2·D valid samples.
- W, 12: sample component width, signed S2.9.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  marks the current input pair as a sample; there is no backpressure.
- UI_real, UI_imag, LI_real, LI_imag  in  W each  upper and lower complex input, S2.9.
- out_valid  out  1  marks the output pair as valid.
- UO_real, UO_imag, LO_real, LO_imag  out  W each  upper and lower complex output, S2.9, registered.

## Operation
- Sample index k counts in_valid cycles since reset, starting at 0. Internal phase counter cnt = k mod 2D, width log2(D)+1.
- Lower delay: L_d(k) = LI(k−D). This is a shift register of D entries that advances only on in_valid. It holds 0 before D samples have been written.
- Switch control: bypass when cnt < D, swap when cnt ≥ D.
  - Bypass: a = UI(k), b = L_d(k).
  - Swap: a = L_d(k), b = UI(k).
- Upper delay: UO(k) = a(k−D), using a shift register of D entries that advances only on in_valid. LO(k) = b(k).
- Resulting order within each 2D block starting at index 0 mod 2D, for j = 0..D−1:
  - Outputs for index D+j carry (UI_j, UI_{D+j}).
  - Outputs for index 2D+j carry (LI_j, LI_{D+j}).
- No arithmetic is done. Bits pass through unchanged, with no rounding and no saturation.
- Fill counter: saturates at D. out_valid asserts only for samples with k ≥ D.
- Cycles where in_valid = 0:
  - No state changes: delays, cnt and the fill counter all hold.
  - out_valid = 0 on the following cycle.
  - The output data registers hold their last value.
- Reset (also mid-operation) clears both delay lines, cnt, the fill counter, all output registers and out_valid to 0. The first in_valid after reset is k = 0, and data in flight is discarded.
- in_valid asserted in the same cycle as rst is ignored.
- cnt wraps from 2D−1 to 0 with no gap. Streaming continues indefinitely, with no block boundary beyond the counter wrap.

## Timing
- Output registers update on the clk edge ending the input cycle, so the outputs for sample k appear the cycle after in_valid for sample k.
- Pipeline latency is D valid samples plus 1 clock. With continuous in_valid starting at cycle 0, out_valid first rises at cycle D+1.
- out_valid equals in_valid delayed by one cycle, gated by fill ≥ D.
- With continuous input, throughput is one pair per clock and there are no bubbles.
- Reset values: all outputs 0, out_valid 0.
- The switch decision uses cnt before its increment in that cycle.

## Test plan
- **Reset values:** rst high for 2 cycles → every output and out_valid equal 0. Hold in_valid = 1 with rst = 1 → out_valid stays 0.
- **D=4 continuous stream:** drive UI_real = k, LI_real = 100+k, imag = −real, for k = 0..15.
  - out_valid first rises at cycle 5.
  - UO_real/LO_real sequence: (0,4), (1,5), (2,6), (3,7), (100,104), (101,105), (102,106), (103,107), (8,12), …
  - Imag parts follow the same pattern.
- **D=1 continuous stream:** inputs u_k = k, l_k = 50+k → outputs (0,1), (50,51), (2,3), (52,53), alternating every clock.
- **Stall insertion, D=4:** insert random in_valid = 0 gaps into the stream of scenario 2.
  - The output sequence is identical to scenario 2, with out_valid low exactly one cycle after each gap.
  - Data registers hold during the gaps.
- **Mid-stream reset, D=4:** pulse rst after k = 6, then restart at k = 0 with new values (UI_real = 200+k) → out_valid stays low for 4 samples, then the output is (200,204), … with no leftover pre-reset data.
- **Extreme values:** UI = 0x7FF/0x800 and LI = 0x800/0x7FF, alternating → outputs are bit-exact copies, with no sign corruption.
